seg_display_mux: RTL

//  Time-multiplexed 4-digit seven-segment driver for the stopwatch display path.

---
 rtl/seg_display_pkg.sv | 47 ++++
 rtl/bcd_to_seg.sv | 14 +
 rtl/seg_display_mux.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/seg_display_pkg.sv
// Shared constants for the stopwatch seven-segment display path: active-low
// segment patterns, dark-output levels, load FSM states and size defaults.
package seg_display_pkg;

    localparam int NUM_DIGITS_DEF = 4;
    localparam int DIGIT_W_DEF    = 4;

    // Active-low patterns, bit 0 = segment a .. bit 6 = segment g
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic       DP_OFF    = 1'b1;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } load_state_t;

    function automatic logic [6:0] seg_pattern(input logic [3:0] code);
        logic [6:0] pat;
        case (code)
            4'h0:    pat = SEG_0;
            4'h1:    pat = SEG_1;
            4'h2:    pat = SEG_2;
            4'h3:    pat = SEG_3;
            4'h4:    pat = SEG_4;
            4'h5:    pat = SEG_5;
            4'h6:    pat = SEG_6;
            4'h7:    pat = SEG_7;
            4'h8:    pat = SEG_8;
            4'h9:    pat = SEG_9;
            4'hA:    pat = SEG_DASH;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational digit-code to active-low seven-segment pattern decoder.
module bcd_to_seg
    import seg_display_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);

    // Pure lookup; codes 0xB..0xF decode to all segments dark
    always_comb begin
        seg = seg_pattern(code);
    end

endmodule

// File: rtl/seg_display_mux.sv
// Time-multiplexed seven-segment driver with tear-free frame loading and blink.
// Optional build macro LEADING_ZERO_BLANK_EN suppresses leading zero digits.
module seg_display_mux
    import seg_display_pkg::*;
#(
    parameter int NUM_DIGITS = NUM_DIGITS_DEF,
    parameter int DIGIT_W    = DIGIT_W_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          scan_tick,
    input  logic                          blink_tick,
    input  logic                          load_valid,
    output logic                          load_ready,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] load_digits,
    input  logic [NUM_DIGITS-1:0]         load_blink_mask,
    input  logic [NUM_DIGITS-1:0]         load_dp,
    output logic [NUM_DIGITS-1:0]         an,
    output logic [6:0]                    seg,
    output logic                          dp
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    load_state_t                   state_r;
    logic [IDX_W-1:0]              scan_idx_r;
    logic                          blink_phase_r;
    logic [NUM_DIGITS*DIGIT_W-1:0] active_digits_r;
    logic [NUM_DIGITS-1:0]         active_mask_r;
    logic [NUM_DIGITS-1:0]         active_dp_r;
    logic [NUM_DIGITS*DIGIT_W-1:0] staged_digits_r;
    logic [NUM_DIGITS-1:0]         staged_mask_r;
    logic [NUM_DIGITS-1:0]         staged_dp_r;

    logic [DIGIT_W-1:0]    code_s;
    logic [6:0]            dec_seg_s;
    logic                  blank_lz_s;
    logic [NUM_DIGITS-1:0] an_s;
    logic [6:0]            seg_s;
    logic                  dp_s;

    assign code_s = active_digits_r[scan_idx_r*DIGIT_W +: DIGIT_W];

    bcd_to_seg u_dec (
        .code (code_s),
        .seg  (dec_seg_s)
    );

`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] upper_zero_s;

    // upper_zero_s[k]: this digit and every more-significant digit are zero
    always_comb begin
        logic run;
        run          = 1'b1;
        upper_zero_s = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            run             = run && (active_digits_r[k*DIGIT_W +: DIGIT_W] == '0);
            upper_zero_s[k] = run;
        end
    end

    // The rightmost digit always shows, so a zero reading is never fully dark
    always_comb begin
        if (scan_idx_r != '0) begin
            blank_lz_s = upper_zero_s[scan_idx_r];
        end else begin
            blank_lz_s = 1'b0;
        end
    end
`else
    assign blank_lz_s = 1'b0;
`endif

    // Next display drive for the currently scanned position
    always_comb begin
        an_s  = '1;
        seg_s = SEG_BLANK;
        dp_s  = DP_OFF;
        if (active_mask_r[scan_idx_r] && blink_phase_r) begin
            an_s  = '1;
            seg_s = SEG_BLANK;
            dp_s  = DP_OFF;
        end else begin
            an_s = ~(NUM_DIGITS'(1) << scan_idx_r);
            if (blank_lz_s) begin
                seg_s = SEG_BLANK;
            end else begin
                seg_s = dec_seg_s;
            end
            dp_s = ~active_dp_r[scan_idx_r];
        end
    end

    // Scan position and blink phase; both ticks in one cycle both take effect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_idx_r    <= '0;
            blink_phase_r <= 1'b0;
        end else begin
            if (scan_tick) begin
                scan_idx_r <= (scan_idx_r == LAST_IDX) ? '0 : scan_idx_r + IDX_W'(1);
            end
            if (blink_tick) begin
                blink_phase_r <= ~blink_phase_r;
            end
        end
    end

    // Load FSM: stage on handshake, commit on the scan tick that wraps to position 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r         <= ST_IDLE;
            load_ready      <= 1'b1;
            staged_digits_r <= '0;
            staged_mask_r   <= '0;
            staged_dp_r     <= '0;
            active_digits_r <= '0;
            active_mask_r   <= '0;
            active_dp_r     <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (load_valid && load_ready) begin
                        staged_digits_r <= load_digits;
                        staged_mask_r   <= load_blink_mask;
                        staged_dp_r     <= load_dp;
                        state_r         <= ST_PENDING;
                        load_ready      <= 1'b0;
                    end
                end
                ST_PENDING: begin
                    if (scan_tick && (scan_idx_r == LAST_IDX)) begin
                        active_digits_r <= staged_digits_r;
                        active_mask_r   <= staged_mask_r;
                        active_dp_r     <= staged_dp_r;
                        state_r         <= ST_IDLE;
                        load_ready      <= 1'b1;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    load_ready <= 1'b1;
                end
            endcase
        end
    end

    // Registered board drive, dark while in reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an  <= '1;
            seg <= SEG_BLANK;
            dp  <= DP_OFF;
        end else begin
            an  <= an_s;
            seg <= seg_s;
            dp  <= dp_s;
        end
    end

endmodule
